scr1_ahb_mem_arb: RTL and testbench
===================================

SCR1_AHB_MEM_ARB -- requirements
Module: scr1_ahb_mem_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive dmem grants while imem waits before imem is forced a grant (fixed-priority mode only; range 1..15).
REQ-002 clk  in  1  sole clock, all state on posedge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 imem_htrans  in  2  imem AHB-Lite transfer type.
REQ-005 imem_haddr  in  SCR1_AHB_WIDTH  imem address.
REQ-006 imem_hsize  in  3  imem size.
REQ-007 imem_hready  out  1  imem ready.
REQ-008 imem_hrdata  out  SCR1_AHB_WIDTH  imem read data.
REQ-009 imem_hresp  out  1  imem response.
REQ-010 dmem_htrans  in  2  dmem transfer type.
REQ-011 dmem_haddr  in  SCR1_AHB_WIDTH  dmem address.
REQ-012 dmem_hsize  in  3  dmem size.
REQ-013 dmem_hwrite  in  1  dmem write.
REQ-014 dmem_hwdata  in  SCR1_AHB_WIDTH  dmem write data.
REQ-015 dmem_hready  out  1  dmem ready.
REQ-016 dmem_hrdata  out  SCR1_AHB_WIDTH  dmem read data.
REQ-017 dmem_hresp  out  1  dmem response.
REQ-018 s_htrans / s_haddr / s_hsize / s_hwrite / s_hwdata  out  2 / SCR1_AHB_WIDTH / 3 / 1 / SCR1_AHB_WIDTH  shared slave port.
REQ-019 s_hready / s_hrdata / s_hresp  in  1 / SCR1_AHB_WIDTH / 1  slave ready, read data, response.

Function
REQ-020 Data-phase owner register dph in {NONE, IMEM, DMEM}; slot = (dph==NONE) | s_hready.
REQ-021 Request X = pend_X | (X_htrans[1] & ~pend_X); at most one of pend_imem/pend_dmem set at any time.
REQ-022 In a slot with requesters: winner W by policy; s_htrans=NONSEQ; address/size/write from capture regs if pend_W, else live W inputs; dph<=W; pend_W<=0.
REQ-023 In a slot with no requester: s_htrans=IDLE (2'b00); dph<=NONE.
REQ-024 Outside a slot: slave address outputs driven as for the winner latched at the last slot, s_htrans=IDLE if none.
REQ-025 X_hready: s_hready when dph==X; 0 when pend_X; 1 when X idle with no outstanding data phase; when waiting in address phase, 1 only in the slot granting X live.
REQ-026 Capture: dph==X & s_hready & ~s_hresp & X_htrans[1] & X loses -> latch addr/size/write, pend_X<=1 (X sees its address accepted).
REQ-027 X_hrdata = s_hrdata; X_hresp = (dph==X) & s_hresp; s_hwdata = dmem_hwdata when dph==DMEM, else 0.
REQ-028 Two-cycle ERROR passes through unmodified; no capture in either ERROR cycle.
REQ-029 Latency: uncontended transfer adds 0 cycles; captured transfer issues at the earliest slot it wins.

Reset
REQ-030 Reset: dph=NONE, pend_*=0, starve count=0, last-grant=DMEM; s_htrans=0, imem_hready=dmem_hready=1, hresp outputs 0; reset mid-transfer abandons it without slave completion.

Configuration
REQ-031 SCR1_AHB_ARB_RR_EN defined: both requesting -> grant master not granted at previous slot; STARVE_LIMIT ignored.
REQ-032 Not defined: dmem wins ties, except imem wins once the starve counter (incremented per dmem grant while imem requests, cleared on imem grant) reaches STARVE_LIMIT.

Verification
REQ-033 imem-only NONSEQ 0x200, s_hready=1 -> s_haddr=0x200 same cycle, imem_hready=1, zero added latency.
REQ-034 imem and dmem NONSEQ same cycle, fixed mode -> dmem granted, imem_hready=0 until next slot, then s_haddr=imem address.
REQ-035 dmem back-to-back while imem waits, STARVE_LIMIT=4 -> imem granted after the 4th dmem grant.
REQ-036 dmem data phase ending while dmem issues new NONSEQ and imem wins -> dmem captured, dmem_hready=0 until replayed transfer completes, hwdata held correctly.
REQ-037 s_hresp=1 two cycles on dmem read -> dmem_hresp=1 both cycles, imem_hresp=0, no capture; rst_n low mid-stall -> outputs at reset values next edge.

Source files
------------

// File: rtl/scr1_ahb_mem_arb.sv
// Arbiter for the imem and dmem AHB-Lite masters sharing one slave port. Addresses that lose arbitration are captured and replayed.
// Optional macro SCR1_AHB_ARB_RR_EN: round-robin ties. Default build: dmem priority with an imem starvation guard.
module scr1_ahb_mem_arb #(
    parameter int SCR1_AHB_WIDTH = 32,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                imem_htrans,
    input  logic [SCR1_AHB_WIDTH-1:0] imem_haddr,
    input  logic [2:0]                imem_hsize,
    output logic                      imem_hready,
    output logic [SCR1_AHB_WIDTH-1:0] imem_hrdata,
    output logic                      imem_hresp,
    input  logic [1:0]                dmem_htrans,
    input  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr,
    input  logic [2:0]                dmem_hsize,
    input  logic                      dmem_hwrite,
    input  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata,
    output logic                      dmem_hready,
    output logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata,
    output logic                      dmem_hresp,
    output logic [1:0]                s_htrans,
    output logic [SCR1_AHB_WIDTH-1:0] s_haddr,
    output logic [2:0]                s_hsize,
    output logic                      s_hwrite,
    output logic [SCR1_AHB_WIDTH-1:0] s_hwdata,
    input  logic                      s_hready,
    input  logic [SCR1_AHB_WIDTH-1:0] s_hrdata,
    input  logic                      s_hresp
);

    typedef enum logic [1:0] {
        DPH_NONE = 2'd0,
        DPH_IMEM = 2'd1,
        DPH_DMEM = 2'd2
    } dph_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    dph_t                      r_dph;
    logic                      r_pend_imem;
    logic                      r_pend_dmem;
    logic [SCR1_AHB_WIDTH-1:0] r_imem_haddr;
    logic [2:0]                r_imem_hsize;
    logic [SCR1_AHB_WIDTH-1:0] r_dmem_haddr;
    logic [2:0]                r_dmem_hsize;
    logic                      r_dmem_hwrite;
`ifdef SCR1_AHB_ARB_RR_EN
    logic                      r_last_imem;
`else
    localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0]                r_starve_cnt;
`endif

    logic w_ilive;
    logic w_dlive;
    logic w_ireq;
    logic w_dreq;
    logic w_slot;
    logic w_imem_wins;
    logic w_gnt_imem;
    logic w_gnt_dmem;
    logic w_cap_imem;
    logic w_cap_dmem;
    logic w_sel_imem;
    logic w_sel_req;

    // Live requests are masked while reset is held so the outputs show their reset values.
    assign w_ilive = rst_n & imem_htrans[1];
    assign w_dlive = rst_n & dmem_htrans[1];
    assign w_ireq  = r_pend_imem | (w_ilive & ~r_pend_imem);
    assign w_dreq  = r_pend_dmem | (w_dlive & ~r_pend_dmem);
    assign w_slot  = (r_dph == DPH_NONE) | s_hready;

`ifdef SCR1_AHB_ARB_RR_EN
    assign w_imem_wins = w_ireq & (~w_dreq | ~r_last_imem);
`else
    assign w_imem_wins = w_ireq & (~w_dreq | (r_starve_cnt >= STARVE_MAX));
`endif

    assign w_gnt_imem = w_slot & w_imem_wins;
    assign w_gnt_dmem = w_slot & w_dreq & ~w_imem_wins;

    // The data-phase owner believes its next address was accepted. If it loses, hold that address for replay.
    assign w_cap_imem = (r_dph == DPH_IMEM) & s_hready & ~s_hresp & w_ilive & w_gnt_dmem;
    assign w_cap_dmem = (r_dph == DPH_DMEM) & s_hready & ~s_hresp & w_dlive & w_gnt_imem;

    // Outside a slot the bus stays connected to the master that owns the data phase.
    assign w_sel_imem = w_slot ? w_imem_wins : (r_dph == DPH_IMEM);
    assign w_sel_req  = w_slot ? (w_ireq | w_dreq) : (w_sel_imem ? w_ilive : w_dlive);

    assign s_htrans = w_sel_req ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_haddr  = w_sel_imem ? (r_pend_imem ? r_imem_haddr : imem_haddr)
                                 : (r_pend_dmem ? r_dmem_haddr : dmem_haddr);
    assign s_hsize  = w_sel_imem ? (r_pend_imem ? r_imem_hsize : imem_hsize)
                                 : (r_pend_dmem ? r_dmem_hsize : dmem_hsize);
    assign s_hwrite = ~w_sel_imem & (r_pend_dmem ? r_dmem_hwrite : dmem_hwrite);
    assign s_hwdata = (r_dph == DPH_DMEM) ? dmem_hwdata : '0;

    assign imem_hrdata = s_hrdata;
    assign dmem_hrdata = s_hrdata;
    assign imem_hresp  = (r_dph == DPH_IMEM) & s_hresp;
    assign dmem_hresp  = (r_dph == DPH_DMEM) & s_hresp;

    always_comb begin
        if (r_dph == DPH_IMEM)  imem_hready = s_hready;
        else if (r_pend_imem)   imem_hready = 1'b0;
        else if (!w_ilive)      imem_hready = 1'b1;
        else                    imem_hready = w_gnt_imem;

        if (r_dph == DPH_DMEM)  dmem_hready = s_hready;
        else if (r_pend_dmem)   dmem_hready = 1'b0;
        else if (!w_dlive)      dmem_hready = 1'b1;
        else                    dmem_hready = w_gnt_dmem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dph         <= DPH_NONE;
            r_pend_imem   <= 1'b0;
            r_pend_dmem   <= 1'b0;
            r_imem_haddr  <= '0;
            r_imem_hsize  <= '0;
            r_dmem_haddr  <= '0;
            r_dmem_hsize  <= '0;
            r_dmem_hwrite <= 1'b0;
`ifdef SCR1_AHB_ARB_RR_EN
            r_last_imem   <= 1'b0;
`else
            r_starve_cnt  <= '0;
`endif
        end else begin
            if (w_slot) begin
                if (w_gnt_imem)      r_dph <= DPH_IMEM;
                else if (w_gnt_dmem) r_dph <= DPH_DMEM;
                else                 r_dph <= DPH_NONE;
            end

            if (w_gnt_imem)      r_pend_imem <= 1'b0;
            else if (w_cap_imem) r_pend_imem <= 1'b1;
            if (w_gnt_dmem)      r_pend_dmem <= 1'b0;
            else if (w_cap_dmem) r_pend_dmem <= 1'b1;

            if (w_cap_imem) begin
                r_imem_haddr <= imem_haddr;
                r_imem_hsize <= imem_hsize;
            end
            if (w_cap_dmem) begin
                r_dmem_haddr  <= dmem_haddr;
                r_dmem_hsize  <= dmem_hsize;
                r_dmem_hwrite <= dmem_hwrite;
            end

`ifdef SCR1_AHB_ARB_RR_EN
            if (w_gnt_imem)      r_last_imem <= 1'b1;
            else if (w_gnt_dmem) r_last_imem <= 1'b0;
`else
            if (w_gnt_imem)
                r_starve_cnt <= '0;
            else if (w_gnt_dmem && w_ireq && (r_starve_cnt != 4'hF))
                r_starve_cnt <= r_starve_cnt + 4'd1;
`endif
        end
    end

endmodule

// File: tb/tb_scr1_ahb_mem_arb.sv
// Self-checking bench for scr1_ahb_mem_arb: reset vectors, directed sequences, and a randomized run against a reference model.
module tb_scr1_ahb_mem_arb;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  imem_htrans, dmem_htrans, s_htrans;
    logic [31:0] imem_haddr, dmem_haddr, s_haddr, dmem_hwdata, s_hwdata, s_hrdata, imem_hrdata, dmem_hrdata;
    logic [2:0]  imem_hsize, dmem_hsize, s_hsize;
    logic        dmem_hwrite, s_hwrite, s_hready, s_hresp;
    logic        imem_hready, imem_hresp, dmem_hready, dmem_hresp;

    scr1_ahb_mem_arb #(.SCR1_AHB_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_htrans(imem_htrans), .imem_haddr(imem_haddr), .imem_hsize(imem_hsize),
        .imem_hready(imem_hready), .imem_hrdata(imem_hrdata), .imem_hresp(imem_hresp),
        .dmem_htrans(dmem_htrans), .dmem_haddr(dmem_haddr), .dmem_hsize(dmem_hsize),
        .dmem_hwrite(dmem_hwrite), .dmem_hwdata(dmem_hwdata),
        .dmem_hready(dmem_hready), .dmem_hrdata(dmem_hrdata), .dmem_hresp(dmem_hresp),
        .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hsize(s_hsize), .s_hwrite(s_hwrite),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] iTrans; logic [31:0] iAddr; logic [2:0] iSize;
        logic [1:0] dTrans; logic [31:0] dAddr; logic [2:0] dSize; logic dWrite; logic [31:0] dWdata;
        logic sReady; logic sResp; logic [31:0] sRdata;
    } stim_t;

    typedef struct {
        stim_t      stim;
        logic [1:0] eTrans; logic [31:0] eAddr; logic eWrite; logic chkAddr;
        logic       eIReady; logic eDReady;
    } vec_t;

    int checks = 0;
    int passes = 0;

    // Reference model state: owner 0 none / 1 imem / 2 dmem, one pending slot per master.
    int          mOwner;
    bit          mPend[1:2];
    logic [31:0] mCapAddr[1:2];
    logic [2:0]  mCapSize[1:2];
    logic        mCapWrite;
    int          mStarve;
    int          mLast;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.iTrans = 2'b00; s.iAddr = '0; s.iSize = 3'd2;
        s.dTrans = 2'b00; s.dAddr = '0; s.dSize = 3'd2; s.dWrite = 1'b0; s.dWdata = '0;
        s.sReady = 1'b1;  s.sResp = 1'b0; s.sRdata = '0;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        imem_htrans = s.iTrans; imem_haddr = s.iAddr; imem_hsize = s.iSize;
        dmem_htrans = s.dTrans; dmem_haddr = s.dAddr; dmem_hsize = s.dSize;
        dmem_hwrite = s.dWrite; dmem_hwdata = s.dWdata;
        s_hready = s.sReady; s_hresp = s.sResp; s_hrdata = s.sRdata;
    endtask

    task automatic driveCycle(input stim_t s);
        @(negedge clk);
        applyStimulus(s);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(idleStim());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mOwner = 0; mPend[1] = 0; mPend[2] = 0; mStarve = 0; mLast = 2;
    endtask

    task automatic modelStep(input stim_t s);
        bit          live[1:2];
        bit          req[1:2];
        logic [31:0] lAddr[1:2];
        logic [2:0]  lSize[1:2];
        bit          slot;
        int          win;
        logic        expReady;
        live[1] = s.iTrans[1]; live[2] = s.dTrans[1];
        lAddr[1] = s.iAddr;    lAddr[2] = s.dAddr;
        lSize[1] = s.iSize;    lSize[2] = s.dSize;
        slot = (mOwner == 0) || s.sReady;
        for (int m = 1; m <= 2; m++) req[m] = mPend[m] || live[m];
        win = 0;
        if (slot && req[1] && req[2]) begin
`ifdef SCR1_AHB_ARB_RR_EN
            win = (mLast == 2) ? 1 : 2;
`else
            win = (mStarve >= LIMIT) ? 1 : 2;
`endif
        end else if (slot && req[1]) win = 1;
        else if (slot && req[2]) win = 2;

        for (int m = 1; m <= 2; m++) begin
            if (mOwner == m)  expReady = s.sReady;
            else if (mPend[m]) expReady = 1'b0;
            else if (!live[m]) expReady = 1'b1;
            else               expReady = (win == m);
            checkOutput($sformatf("rand_hready_m%0d", m), (m == 1) ? imem_hready : dmem_hready, expReady);
            checkOutput($sformatf("rand_hresp_m%0d", m), (m == 1) ? imem_hresp : dmem_hresp,
                        (mOwner == m) && s.sResp);
        end
        checkOutput("rand_imem_hrdata", imem_hrdata, s.sRdata);
        checkOutput("rand_dmem_hrdata", dmem_hrdata, s.sRdata);
        checkOutput("rand_hwdata", s_hwdata, (mOwner == 2) ? s.dWdata : 32'd0);
        if (slot) begin
            checkOutput("rand_htrans", s_htrans, (win != 0) ? 2'b10 : 2'b00);
            if (win != 0) begin
                checkOutput("rand_haddr", s_haddr, mPend[win] ? mCapAddr[win] : lAddr[win]);
                checkOutput("rand_hsize", s_hsize, mPend[win] ? mCapSize[win] : lSize[win]);
                checkOutput("rand_hwrite", s_hwrite, (win == 2) ? (mPend[2] ? mCapWrite : s.dWrite) : 1'b0);
            end
            if (mOwner != 0 && win != 0 && win != mOwner && !s.sResp && live[mOwner]) begin
                mPend[mOwner]    = 1;
                mCapAddr[mOwner] = lAddr[mOwner];
                mCapSize[mOwner] = lSize[mOwner];
                if (mOwner == 2) mCapWrite = s.dWrite;
            end
            if (win == 1) mStarve = 0;
            else if (win == 2 && req[1]) mStarve++;
            if (win != 0) begin
                mPend[win] = 0;
                mLast = win;
            end
            mOwner = win;
        end
    endtask

    vec_t  vecs[6];
    stim_t s;

    initial begin
        for (int i = 0; i < 6; i++) begin
            vecs[i].stim = idleStim();
            vecs[i].eTrans = 2'b10; vecs[i].eWrite = 1'b0; vecs[i].chkAddr = 1'b1;
            vecs[i].eIReady = 1'b1; vecs[i].eDReady = 1'b1;
        end
        vecs[0].stim.iTrans = 2'b10; vecs[0].stim.iAddr = 32'h200; vecs[0].eAddr = 32'h200;
        vecs[1].stim.iTrans = 2'b10; vecs[1].stim.iAddr = 32'h300;
        vecs[1].stim.dTrans = 2'b10; vecs[1].stim.dAddr = 32'h1000; vecs[1].stim.dWrite = 1'b1;
`ifdef SCR1_AHB_ARB_RR_EN
        vecs[1].eAddr = 32'h300; vecs[1].eWrite = 1'b0; vecs[1].eDReady = 1'b0;
`else
        vecs[1].eAddr = 32'h1000; vecs[1].eWrite = 1'b1; vecs[1].eIReady = 1'b0;
`endif
        vecs[2].stim.dTrans = 2'b10; vecs[2].stim.dAddr = 32'h44; vecs[2].eAddr = 32'h44;
        vecs[3].stim.iTrans = 2'b01; vecs[3].eTrans = 2'b00; vecs[3].chkAddr = 1'b0;
        vecs[4].stim.iTrans = 2'b11; vecs[4].stim.iAddr = 32'h204; vecs[4].eAddr = 32'h204;
        vecs[5].stim.iTrans = 2'b10; vecs[5].stim.iAddr = 32'h208; vecs[5].stim.sReady = 1'b0;
        vecs[5].eAddr = 32'h208;

        // Reset values while both masters are requesting.
        rst_n = 1'b0;
        s = idleStim(); s.iTrans = 2'b10; s.dTrans = 2'b10; s.sResp = 1'b1;
        applyStimulus(s);
        #1;
        checkOutput("rst_htrans", s_htrans, 2'b00);
        checkOutput("rst_imem_hready", imem_hready, 1'b1);
        checkOutput("rst_dmem_hready", dmem_hready, 1'b1);
        checkOutput("rst_imem_hresp", imem_hresp, 1'b0);
        checkOutput("rst_dmem_hresp", dmem_hresp, 1'b0);

        for (int i = 0; i < 6; i++) begin
            doReset();
            driveCycle(vecs[i].stim);
            checkOutput($sformatf("vec%0d_htrans", i), s_htrans, vecs[i].eTrans);
            if (vecs[i].chkAddr) begin
                checkOutput($sformatf("vec%0d_haddr", i), s_haddr, vecs[i].eAddr);
                checkOutput($sformatf("vec%0d_hwrite", i), s_hwrite, vecs[i].eWrite);
            end
            checkOutput($sformatf("vec%0d_imem_hready", i), imem_hready, vecs[i].eIReady);
            checkOutput($sformatf("vec%0d_dmem_hready", i), dmem_hready, vecs[i].eDReady);
        end

`ifndef SCR1_AHB_ARB_RR_EN
        // Tie goes to dmem; imem waits through a wait state and issues at the next slot.
        doReset();
        s = idleStim(); s.iTrans = 2'b10; s.iAddr = 32'h300; s.dTrans = 2'b10; s.dAddr = 32'h1000;
        driveCycle(s);
        checkOutput("tie_haddr", s_haddr, 32'h1000);
        checkOutput("tie_imem_hready", imem_hready, 1'b0);
        s.dTrans = 2'b00; s.sReady = 1'b0;
        driveCycle(s);
        checkOutput("tie_wait_imem_hready", imem_hready, 1'b0);
        checkOutput("tie_wait_dmem_hready", dmem_hready, 1'b0);
        s.sReady = 1'b1;
        driveCycle(s);
        checkOutput("tie_next_haddr", s_haddr, 32'h300);
        checkOutput("tie_next_imem_hready", imem_hready, 1'b1);

        // Starvation guard, then replay of the captured dmem write.
        doReset();
        s = idleStim(); s.iTrans = 2'b10; s.iAddr = 32'h400; s.dTrans = 2'b10; s.dWrite = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            s.dAddr = 32'h2000 + 32'(4 * k);
            driveCycle(s);
            checkOutput($sformatf("starve_g%0d_haddr", k), s_haddr, s.dAddr);
            checkOutput($sformatf("starve_g%0d_imem_hready", k), imem_hready, 1'b0);
        end
        s.dAddr = 32'h2014;
        driveCycle(s);
        checkOutput("starve_imem_haddr", s_haddr, 32'h400);
        checkOutput("starve_imem_hready", imem_hready, 1'b1);
        checkOutput("starve_dmem_hready", dmem_hready, 1'b1);
        s.iTrans = 2'b00; s.dTrans = 2'b00; s.dAddr = 32'h9990; s.dWrite = 1'b0; s.dWdata = 32'hCAFE0014;
        driveCycle(s);
        checkOutput("replay_htrans", s_htrans, 2'b10);
        checkOutput("replay_haddr", s_haddr, 32'h2014);
        checkOutput("replay_hwrite", s_hwrite, 1'b1);
        checkOutput("replay_dmem_hready", dmem_hready, 1'b0);
        checkOutput("replay_hwdata_imem", s_hwdata, 32'h0);
        s.sReady = 1'b0;
        driveCycle(s);
        checkOutput("replay_wait_hwdata", s_hwdata, 32'hCAFE0014);
        checkOutput("replay_wait_dmem_hready", dmem_hready, 1'b0);
        s.sReady = 1'b1;
        driveCycle(s);
        checkOutput("replay_done_hwdata", s_hwdata, 32'hCAFE0014);
        checkOutput("replay_done_dmem_hready", dmem_hready, 1'b1);

        // Two-cycle ERROR responses on dmem, then on imem with no capture.
        doReset();
        s = idleStim(); s.dTrans = 2'b10; s.dAddr = 32'h80;
        driveCycle(s);
        s.dAddr = 32'h84; s.sReady = 1'b0; s.sResp = 1'b1;
        driveCycle(s);
        checkOutput("err1_dmem_hresp", dmem_hresp, 1'b1);
        checkOutput("err1_imem_hresp", imem_hresp, 1'b0);
        checkOutput("err1_dmem_hready", dmem_hready, 1'b0);
        s.sReady = 1'b1;
        driveCycle(s);
        checkOutput("err2_dmem_hresp", dmem_hresp, 1'b1);
        checkOutput("err2_imem_hresp", imem_hresp, 1'b0);
        checkOutput("err2_dmem_hready", dmem_hready, 1'b1);
        s = idleStim(); s.iTrans = 2'b10; s.iAddr = 32'h600;
        driveCycle(s);
        s.iAddr = 32'h604; s.dTrans = 2'b10; s.dAddr = 32'h90; s.sReady = 1'b0; s.sResp = 1'b1;
        driveCycle(s);
        checkOutput("ierr1_imem_hresp", imem_hresp, 1'b1);
        s.sReady = 1'b1;
        driveCycle(s);
        checkOutput("ierr2_imem_hresp", imem_hresp, 1'b1);
        checkOutput("ierr2_haddr", s_haddr, 32'h90);
        s = idleStim();
        driveCycle(s);
        checkOutput("ierr_nocap_htrans", s_htrans, 2'b00);
        checkOutput("ierr_nocap_imem_hready", imem_hready, 1'b1);
`endif

        // Reset asserted while a dmem data phase is stalled with an error pending.
        doReset();
        s = idleStim(); s.dTrans = 2'b10; s.dAddr = 32'hA0;
        driveCycle(s);
        s.dAddr = 32'hA4; s.iTrans = 2'b10; s.iAddr = 32'h700; s.sReady = 1'b0; s.sResp = 1'b1;
        driveCycle(s);
        checkOutput("stall_dmem_hresp", dmem_hresp, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_htrans", s_htrans, 2'b00);
        checkOutput("midrst_dmem_hready", dmem_hready, 1'b1);
        checkOutput("midrst_dmem_hresp", dmem_hresp, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("midrst_edge_imem_hready", imem_hready, 1'b1);
        checkOutput("midrst_edge_dmem_hresp", dmem_hresp, 1'b0);
        checkOutput("midrst_edge_htrans", s_htrans, 2'b00);

        // Randomized traffic against the reference model.
        doReset();
        for (int n = 0; n < 600; n++) begin
            s.iTrans = 2'($urandom_range(0, 3));
            s.iAddr  = $urandom & 32'h0000_FFFC;
            s.iSize  = 3'($urandom_range(0, 2));
            s.dTrans = 2'($urandom_range(0, 3));
            s.dAddr  = $urandom & 32'h0000_FFFC;
            s.dSize  = 3'($urandom_range(0, 2));
            s.dWrite = 1'($urandom_range(0, 1));
            s.dWdata = $urandom;
            s.sReady = ($urandom_range(0, 3) != 0);
            s.sResp  = ($urandom_range(0, 9) == 0);
            s.sRdata = $urandom;
            driveCycle(s);
            modelStep(s);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
